// File: rtl/xnor_popcount_acc.sv
// Binary-convolution accumulator: XNOR-popcount per word pair, signed +/-1 dot-product sum,
// saturated Q8.8 result with a one-cycle ready pulse for the downstream batch-norm stage.
module xnor_popcount_acc #(
  parameter int unsigned VEC_W     = 32,
  parameter int unsigned NUM_WORDS = 9,
  parameter int unsigned FRAC      = 8,
  parameter int unsigned OUT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [VEC_W-1:0] act_bits,
  input  logic [VEC_W-1:0] wgt_bits,
  output logic             in_ready,
  output logic             busy,
  output logic             ready,
  output logic [OUT_W-1:0] data_out
);

  localparam int unsigned PW     = $clog2(VEC_W + 1);
  localparam int unsigned CW     = $clog2(NUM_WORDS + 1);
  localparam int unsigned AccW   = $clog2(VEC_W * NUM_WORDS) + 2;
  localparam int          SatLim = 2 ** (OUT_W - 1 - FRAC);

  typedef enum logic [1:0] {StIdle, StAcc, StDrain, StOut} state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [PW-1:0]           p_q;
  logic                    p_vld_q;
  logic                    drain_q;
  logic signed [AccW-1:0]  acc_q;
  logic                    ready_q;
  logic [OUT_W-1:0]        data_out_q;

  logic [VEC_W-1:0]        match;
  logic [PW-1:0]           pop_d;
  logic signed [AccW-1:0]  contrib;
  int                      acc_int;
  logic [OUT_W-1:0]        data_d;

  always_comb begin
    match = ~(act_bits ^ wgt_bits);
    pop_d = '0;
    for (int unsigned i = 0; i < VEC_W; i++) begin
      pop_d = pop_d + PW'(match[i]);
    end
  end

  // Each matching bit contributes +1, each mismatch -1: 2p - VEC_W.
  always_comb begin
    contrib = AccW'(2 * int'(p_q) - int'(VEC_W));
  end

  always_comb begin
    acc_int = int'(acc_q);
    if (acc_int >= SatLim) begin
      data_d = {1'b0, {(OUT_W - 1){1'b1}}};
    end else if (acc_int <= -SatLim) begin
      data_d = {1'b1, {(OUT_W - 1){1'b0}}};
    end else begin
      data_d = OUT_W'(acc_int <<< FRAC);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      p_q        <= '0;
      p_vld_q    <= 1'b0;
      drain_q    <= 1'b0;
      acc_q      <= '0;
      ready_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      ready_q <= 1'b0;
      p_vld_q <= 1'b0;
      if (p_vld_q) begin
        acc_q <= acc_q + contrib;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= StAcc;
          end
        end
        StAcc: begin
          if (in_valid) begin
            p_q     <= pop_d;
            p_vld_q <= 1'b1;
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == CW'(NUM_WORDS - 1)) begin
              state_q <= StDrain;
              drain_q <= 1'b0;
            end
          end
        end
        // Two cycles: one for the last popcount to reach the accumulator, one to sample it.
        StDrain: begin
          if (drain_q) begin
            state_q    <= StOut;
            ready_q    <= 1'b1;
            data_out_q <= data_d;
          end else begin
            drain_q <= 1'b1;
          end
        end
        StOut: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready = (state_q == StAcc);
  assign busy     = (state_q != StIdle);
  assign ready    = ready_q;
  assign data_out = data_out_q;

endmodule

// File: doc/xnor_popcount_acc.md
Name: xnor_popcount_acc

Overview:
Binary convolution accumulator that sits directly upstream of the batch-norm stage. It receives NUM_WORDS pairs of VEC_W-bit binarized activation and weight words for one output pixel. For each pair it computes the XNOR popcount, converts it to a signed ±1 dot-product contribution, and accumulates the signed sum. It then delivers the sum as a saturated Q8.8 value on data_out, with a one-cycle ready pulse that feeds the batch-norm stage's data_in/ready inputs.

Parameters:
VEC_W, 32, bits per activation/weight word
NUM_WORDS, 9, words accumulated per output (e.g. 3x3 kernel window)
FRAC, 8, fractional bits of the Q8.8 output
OUT_W, 16, output width (signed Q8.8)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin a new accumulation; honoured only in IDLE
in_valid  in  1  act_bits/wgt_bits valid this cycle
act_bits  in  VEC_W  binarized activations (1 = +1, 0 = -1)
wgt_bits  in  VEC_W  binarized weights (same encoding)
in_ready  out  1  block accepts a word this cycle
busy  out  1  state != IDLE
ready  out  1  one-cycle pulse, data_out holds a new result
data_out  out  OUT_W  signed Q8.8 accumulated sum, saturated

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE
  - ready=0, in_ready=0, busy=0, data_out=0
  - word counter=0, accumulator=0, pipeline valid flags=0
  - Reset asserted mid-operation discards the partial result; no ready pulse is produced.
- FSM states: IDLE, ACC, DRAIN, OUT.
  - IDLE: in_ready=0. start=1 clears the accumulator and counter, then moves to ACC. in_valid is ignored in IDLE, including the cycle in which start is sampled.
  - ACC: in_ready=1. A word is accepted on an edge with in_valid=1. The counter increments per accepted word. When the NUM_WORDS-th word is accepted, the FSM moves to DRAIN and in_ready goes to 0 from the next cycle. Bubbles (in_valid=0) stall without side effects.
  - DRAIN: waits for the pipeline to empty (2 cycles), then moves to OUT.
  - OUT: ready=1 for exactly one cycle, then unconditionally returns to IDLE.
  - start is ignored in ACC, DRAIN and OUT.
- Pipeline:
  - Edge E, word accepted: register p = popcount(~(act_bits ^ wgt_bits)), range 0..VEC_W.
  - Edge E+1: acc <= acc + (2p - VEC_W), signed.
  - Edge E+2 after the last word: data_out registered, ready=1 during the following cycle.
- Arithmetic:
  - Accumulator is signed, width ≥ clog2(VEC_W*NUM_WORDS)+2; no internal overflow is allowed.
  - Output is S<<FRAC, saturated to [0x8000, 0x7FFF]. Integer range is -128..+127.996.
  - Any S ≥ 128 gives 0x7FFF. Any S ≤ -128 gives 0x8000 (S = -128 is exact 0x8000).
- data_out holds its value after the ready pulse until the next result or reset.
- Simultaneous events:
  - Last word accepted on the same edge as any start: start is ignored.
  - ready and a new start cannot overlap; the earliest next start is in IDLE, the cycle after OUT.

Test Plan:
1. Reset (rst=0 then 1) -> data_out=0x0000, ready=0, in_ready=0, busy=0. start; 9 words with act=wgt=0xFFFFFFFF -> S=+288 -> ready pulse, data_out=0x7FFF (saturated).
2. 9 words with act=0x00000000, wgt=0xFFFFFFFF -> S=-288 -> data_out=0x8000. 4 matching words then 5 fully mismatched -> S=-32 -> data_out=0xE000.
3. 9 words, each with exactly 16 bits differing (act=0xFFFF0000, wgt=0xFFFFFFFF) -> S=0 -> data_out=0x0000. Word0 matching, word1 with 15 bits differing (p=17), rest with 16 differing -> S=34 -> data_out=0x2200.
4. Latency and stalls: words from test 3 with in_valid low for 3 cycles between words 2 and 3 -> same 0x2200. ready pulses exactly one cycle, 2 edges after the last-word edge. in_ready=0 immediately after the 9th accept. data_out holds 0x2200 afterwards.
5. Protocol: start pulsed during ACC/OUT and in_valid with start in IDLE -> ignored (result unchanged vs. clean run). A 10th word offered after the 9th is not accepted.
6. rst=0 after 5 words of test 1 -> ready never pulses, data_out=0, busy=0. A fresh start with the test 3 data -> 0x0000 (no residue).
